ble_pdu_deframer: RTL and testbench

- Sits directly downstream of ble_cdr.
- Consumes its recovered bit stream (demod_symbol, demod_symbol_clk) and its packet_detected flag, plus the 6-bit RF channel index.
- After packet_detected it de-whitens the bits, assembles LSB-first bytes, parses the 2-byte PDU header, delivers header and payload bytes, and checks CRC-24.
- Reports per-packet done, CRC pass/fail and error status to the downstream byte consumer.

---
 rtl/ble_rx_pkg.sv | 52 +++++
 rtl/ble_dewhiten_crc.sv | 43 ++++
 rtl/ble_pdu_deframer.sv | 157 +++++++++++++++
 tb/tb_ble_pdu_deframer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_rx_pkg.sv
// Shared constants, receive FSM state type and a reference packet whitener for the BLE PDU path.
package ble_rx_pkg;

  localparam logic [23:0] CRC_POLY    = 24'h00065B;
  localparam logic [23:0] CRC_INIT    = 24'h555555;
  localparam logic [7:0]  WHITEN_MASK = 8'h88;
  localparam int          MAX_PDU_LEN = 37;

  localparam int REF_MAX_BYTES = MAX_PDU_LEN + 2;
  localparam int REF_MAX_BITS  = 8 * REF_MAX_BYTES + 24;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CRC} rxState_e;

  // Builds the on-air bit stream (bit i = i-th transmitted bit) for a header+payload byte list:
  // CRC-24 over the PDU bits, appended MSB first, everything whitened from seed {1, chan}.
  function automatic logic [REF_MAX_BITS-1:0] refWhitenPacket(
    input logic [8*REF_MAX_BYTES-1:0] pduBytes,
    input int                         numBytes,
    input logic [5:0]                 chan
  );
    logic [8*REF_MAX_BYTES-1:0] src;
    logic [REF_MAX_BITS-1:0]    txBits;
    logic [7:0]                 wreg;
    logic [23:0]                crc;
    logic                       d;
    logic                       w;
    logic                       fb;
    int                         nData;
    src    = pduBytes;
    txBits = '0;
    wreg   = {1'b1, chan, 1'b0};
    crc    = CRC_INIT;
    nData  = 8 * numBytes;
    for (int i = 0; i < REF_MAX_BITS; i++) begin
      w = 1'b0;
      d = 1'b0;
      if (i < nData + 24) begin
        d   = (i < nData) ? src[0] : crc[23];
        src = src >> 1;
        fb  = crc[23] ^ d;
        crc = {crc[22:0], 1'b0};
        if (fb) crc = crc ^ CRC_POLY;
        w = d ^ wreg[1];
        if (wreg[1]) wreg = wreg ^ WHITEN_MASK;
        wreg = {1'b0, wreg[7:2], 1'b0};
      end
      txBits = {w, txBits[REF_MAX_BITS-1:1]};
    end
    return txBits;
  endfunction

endpackage

// File: rtl/ble_dewhiten_crc.sv
// Per-bit de-whitening LFSR and CRC-24 accumulator; de-whitened bit and CRC look-ahead are combinational.
module ble_dewhiten_crc
  import ble_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        init_i,
  input  logic [5:0]  seed_channel_i,
  input  logic        bit_valid_i,
  input  logic        bit_in_i,
  output logic        d_out_o,
  output logic [23:0] crc_o,
  output logic        crc_zero_next_o
);

  logic [6:0]  lfsr_q;
  logic [6:0]  lfsrMasked;
  logic [6:0]  lfsr_d;
  logic [23:0] crc_d;

  // The 8-bit mask lines up with {lfsr, 1'b0}, so the 7-bit register sees its upper seven bits.
  always_comb begin
    d_out_o         = bit_in_i ^ lfsr_q[0];
    lfsrMasked      = lfsr_q[0] ? (lfsr_q ^ WHITEN_MASK[7:1]) : lfsr_q;
    lfsr_d          = lfsrMasked >> 1;
    crc_d           = {crc_o[22:0], 1'b0} ^ ((crc_o[23] ^ d_out_o) ? CRC_POLY : 24'h000000);
    crc_zero_next_o = (crc_d == 24'h000000);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= '0;
      crc_o  <= '0;
    end else if (init_i) begin
      lfsr_q <= {1'b1, seed_channel_i};
      crc_o  <= CRC_INIT;
    end else if (bit_valid_i) begin
      lfsr_q <= lfsr_d;
      crc_o  <= crc_d;
    end
  end

endmodule

// File: rtl/ble_pdu_deframer.sv
// BLE link-layer PDU deframer: turns the CDR bit stream into header/payload bytes with CRC status.
module ble_pdu_deframer
  import ble_rx_pkg::*;
#(
  parameter int MAX_LEN = MAX_PDU_LEN,
  parameter int TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic [5:0] channel_i,
  input  logic       symbol_i,
  input  logic       symbol_clk_i,
  input  logic       packet_detected_i,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       byte_is_header_o,
  output logic [7:0] pdu_len_o,
  output logic       pkt_done_o,
  output logic       crc_ok_o,
  output logic       pkt_err_o,
  output logic       busy_o
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [6:0] TO_LAST   = 7'(TIMEOUT - 1);

  rxState_e   state_q;
  logic       symClk_q;
  logic       pktDet_q;
  logic [7:0] sr_q;
  logic [2:0] bitCnt_q;
  logic [7:0] byteCnt_q;
  logic [4:0] crcCnt_q;
  logic [6:0] toCnt_q;

  logic       stb;
  logic       startPkt;
  logic       bitValid;
  logic       dBit;
  logic       crcZeroNext;
  logic [7:0] newByte;

  assign stb      = symbol_clk_i & ~symClk_q;
  assign startPkt = (state_q == IDLE) & en_i & packet_detected_i & ~pktDet_q;
  assign bitValid = stb & en_i & (state_q != IDLE);
  assign newByte  = {dBit, sr_q[7:1]};

  ble_dewhiten_crc uDewhitenCrc (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .init_i          (startPkt),
    .seed_channel_i  (channel_i),
    .bit_valid_i     (bitValid),
    .bit_in_i        (symbol_i),
    .d_out_o         (dBit),
    .crc_o           (),
    .crc_zero_next_o (crcZeroNext)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      symClk_q         <= 1'b0;
      pktDet_q         <= 1'b0;
      sr_q             <= '0;
      bitCnt_q         <= '0;
      byteCnt_q        <= '0;
      crcCnt_q         <= '0;
      toCnt_q          <= '0;
      byte_data_o      <= '0;
      byte_valid_o     <= 1'b0;
      byte_is_header_o <= 1'b0;
      pdu_len_o        <= '0;
      pkt_done_o       <= 1'b0;
      crc_ok_o         <= 1'b0;
      pkt_err_o        <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      symClk_q         <= symbol_clk_i;
      pktDet_q         <= packet_detected_i;
      byte_valid_o     <= 1'b0;
      byte_is_header_o <= 1'b0;
      pkt_done_o       <= 1'b0;
      pkt_err_o        <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
        busy_o  <= 1'b0;
        toCnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (startPkt) begin
              bitCnt_q  <= '0;
              byteCnt_q <= '0;
              crcCnt_q  <= '0;
              toCnt_q   <= '0;
              pdu_len_o <= '0;
              crc_ok_o  <= 1'b0;
              busy_o    <= 1'b1;
              state_q   <= HEADER;
            end
          end
          default: begin
            // A strobe always clears the idle counter, so it takes priority over the timeout.
            if (bitValid) begin
              toCnt_q <= '0;
              sr_q    <= newByte;
              if (state_q == CRC) begin
                crcCnt_q <= crcCnt_q + 5'd1;
                if (crcCnt_q == 5'd23) begin
                  pkt_done_o <= 1'b1;
                  crc_ok_o   <= crcZeroNext;
                  busy_o     <= 1'b0;
                  state_q    <= IDLE;
                end
              end else begin
                bitCnt_q <= bitCnt_q + 3'd1;
                if (bitCnt_q == 3'd7) begin
                  byte_valid_o     <= 1'b1;
                  byte_data_o      <= newByte;
                  byte_is_header_o <= (state_q == HEADER);
                  byteCnt_q        <= byteCnt_q + 8'd1;
                  if (state_q == HEADER) begin
                    if (byteCnt_q == 8'd1) begin
                      pdu_len_o <= newByte;
                      byteCnt_q <= '0;
                      if (newByte > MAX_LEN_B) begin
                        pkt_err_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state_q   <= IDLE;
                      end else if (newByte == 8'd0) begin
                        state_q <= CRC;
                      end else begin
                        state_q <= PAYLOAD;
                      end
                    end
                  end else if (byteCnt_q == pdu_len_o - 8'd1) begin
                    state_q <= CRC;
                  end
                end
              end
            end else if (toCnt_q == TO_LAST) begin
              pkt_err_o <= 1'b1;
              busy_o    <= 1'b0;
              toCnt_q   <= '0;
              state_q   <= IDLE;
            end else begin
              toCnt_q <= toCnt_q + 7'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ble_pdu_deframer.sv
// Scoreboard bench for ble_pdu_deframer: directed packets whitened by the package reference function.
module tb_ble_pdu_deframer;
  import ble_rx_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic [5:0] channel;
  logic       symbol;
  logic       symbolClk;
  logic       packetDetected;
  logic [7:0] byteData;
  logic       byteValid;
  logic       byteIsHeader;
  logic [7:0] pduLen;
  logic       pktDone;
  logic       crcOk;
  logic       pktErr;
  logic       busy;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       flag;
    int         cycle;
  } expEvent_t;

  expEvent_t expQ[$];
  int        cyc;
  int        vectors;
  int        miscompares;

  ble_pdu_deframer dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .en_i              (en),
    .channel_i         (channel),
    .symbol_i          (symbol),
    .symbol_clk_i      (symbolClk),
    .packet_detected_i (packetDetected),
    .byte_data_o       (byteData),
    .byte_valid_o      (byteValid),
    .byte_is_header_o  (byteIsHeader),
    .pdu_len_o         (pduLen),
    .pkt_done_o        (pktDone),
    .crc_ok_o          (crcOk),
    .pkt_err_o         (pktErr),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Event kinds: 0 = byte strobe, 1 = pkt_done, 2 = pkt_err.
  task automatic checkEvent(input int kind);
    expEvent_t e;
    checkOutput("event expected", 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("event kind", 32'(kind), 32'(e.kind));
      checkOutput("event cycle", 32'(cyc), 32'(e.cycle));
      if (kind == 0) begin
        checkOutput("byte_data", 32'(byteData), 32'(e.data));
        checkOutput("byte_is_header", 32'(byteIsHeader), 32'(e.flag));
      end else begin
        checkOutput("pdu_len at end", 32'(pduLen), 32'(e.data));
        checkOutput("busy at end", 32'(busy), 32'd0);
        if (kind == 1) checkOutput("crc_ok", 32'(crcOk), 32'(e.flag));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (byteValid) checkEvent(0);
      if (pktDone)   checkEvent(1);
      if (pktErr)    checkEvent(2);
    end
  end

  // expEnd: 0 none, 1 done with good CRC, 2 done with bad CRC, 3 length abort, 4 timeout abort.
  task automatic applyStimulus(input logic [5:0] chan, input logic [7:0] hdr0, input logic [7:0] hdr1,
                               input int nPay, input int flipBit, input int sendBits,
                               input int expBits, input int expEnd);
    logic [8*REF_MAX_BYTES-1:0] pb;
    logic [8*REF_MAX_BYTES-1:0] expB;
    logic [8*REF_MAX_BYTES-1:0] oneB;
    logic [REF_MAX_BITS-1:0]    tx;
    logic [REF_MAX_BITS-1:0]    oneT;
    logic [7:0]                 byteVal;
    expEvent_t                  e;
    int                         s;
    int                         nBytes;
    nBytes = 2 + nPay;
    pb     = '0;
    for (int i = nPay; i >= 1; i--) pb = (pb << 8) | (8*REF_MAX_BYTES)'(i);
    pb   = (pb << 16) | (8*REF_MAX_BYTES)'({hdr1, hdr0});
    tx   = refWhitenPacket(pb, nBytes, chan);
    expB = pb;
    oneB = (8*REF_MAX_BYTES)'(1);
    oneT = REF_MAX_BITS'(1);
    if (flipBit >= 0) begin
      tx = tx ^ (oneT << flipBit);
      if (flipBit < 8 * nBytes) expB = expB ^ (oneB << flipBit);
    end
    channel = chan;
    @(posedge clk); #1;
    packetDetected = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    for (int i = 0; i < nBytes; i++) begin
      byteVal = expB[7:0];
      expB    = expB >> 8;
      if (8 * i + 7 < expBits) begin
        e.kind  = 0;
        e.data  = byteVal;
        e.flag  = (i < 2);
        e.cycle = s + 16 * (8 * i + 7) + 1;
        expQ.push_back(e);
      end
    end
    e.data = hdr1;
    e.flag = (expEnd == 1);
    if (expEnd == 1 || expEnd == 2) begin
      e.kind  = 1;
      e.cycle = s + 16 * (sendBits - 1) + 1;
      expQ.push_back(e);
    end else if (expEnd == 3) begin
      e.kind  = 2;
      e.cycle = s + 16 * 15 + 1;
      expQ.push_back(e);
    end else if (expEnd == 4) begin
      e.kind  = 2;
      e.cycle = s + 16 * (sendBits - 1) + 1 + 64;
      expQ.push_back(e);
    end
    for (int k = 0; k < sendBits; k++) begin
      symbol    = tx[0];
      tx        = tx >> 1;
      symbolClk = 1'b1;
      repeat (8) @(posedge clk);
      #1 symbolClk = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end
    packetDetected = 1'b0;
  endtask

  task automatic settle();
    repeat (100) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    en             = 1'b1;
    channel        = '0;
    symbol         = 1'b0;
    symbolClk      = 1'b0;
    packetDetected = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput("reset byte_data", 32'(byteData), 32'd0);
    checkOutput("reset byte_valid", 32'(byteValid), 32'd0);
    checkOutput("reset byte_is_header", 32'(byteIsHeader), 32'd0);
    checkOutput("reset pdu_len", 32'(pduLen), 32'd0);
    checkOutput("reset pkt_done", 32'(pktDone), 32'd0);
    checkOutput("reset crc_ok", 32'(crcOk), 32'd0);
    checkOutput("reset pkt_err", 32'(pktErr), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);

    $display("[TB] ch37 good packet with a second detect edge while busy");
    fork
      applyStimulus(6'd37, 8'h40, 8'h06, 6, -1, 88, 88, 1);
      begin
        repeat (600) @(posedge clk);
        #3 packetDetected = 1'b0;
        repeat (2) @(posedge clk);
        #3 packetDetected = 1'b1;
        @(posedge clk);
        #3 checkOutput("busy ignores 2nd detect", 32'(busy), 32'd1);
      end
    join
    settle();
    checkOutput("busy after done", 32'(busy), 32'd0);
    checkOutput("crc_ok held", 32'(crcOk), 32'd1);
    checkOutput("pdu_len held", 32'(pduLen), 32'd6);

    $display("[TB] ch37 packet with one payload bit flipped");
    applyStimulus(6'd37, 8'h40, 8'h06, 6, 26, 88, 88, 2);
    settle();

    $display("[TB] ch0 empty payload");
    applyStimulus(6'd0, 8'h42, 8'h00, 0, -1, 40, 40, 1);
    settle();

    $display("[TB] length 0x26 abort");
    applyStimulus(6'd5, 8'h40, 8'h26, 0, -1, 16, 16, 3);
    settle();
    checkOutput("busy after length abort", 32'(busy), 32'd0);

    $display("[TB] ch12 maximum-length packet after abort");
    applyStimulus(6'd12, 8'h02, 8'h25, 37, -1, 336, 336, 1);
    settle();

    $display("[TB] strobes stop after 3 payload bytes");
    applyStimulus(6'd37, 8'h40, 8'h06, 6, -1, 40, 40, 4);
    settle();

    $display("[TB] en dropped mid-payload");
    fork
      applyStimulus(6'd37, 8'h40, 8'h06, 6, -1, 88, 30, 0);
      begin
        repeat (486) @(posedge clk);
        #3 en = 1'b0;
        checkOutput("busy before en drop", 32'(busy), 32'd1);
        @(posedge clk);
        #3 en = 1'b1;
        checkOutput("busy after en drop", 32'(busy), 32'd0);
        checkOutput("pdu_len held over en drop", 32'(pduLen), 32'd6);
      end
    join
    settle();
    checkOutput("busy stays low after en drop", 32'(busy), 32'd0);

    $display("[TB] reset pulsed mid-payload");
    fork
      applyStimulus(6'd37, 8'h40, 8'h06, 6, -1, 32, 30, 0);
      begin
        repeat (486) @(posedge clk);
        #3 reset = 1'b1;
        #2;
        checkOutput("mid-reset busy", 32'(busy), 32'd0);
        checkOutput("mid-reset pdu_len", 32'(pduLen), 32'd0);
        checkOutput("mid-reset byte_data", 32'(byteData), 32'd0);
        checkOutput("mid-reset crc_ok", 32'(crcOk), 32'd0);
        wait (packetDetected == 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
      end
    join
    settle();

    $display("[TB] recovery packet");
    applyStimulus(6'd37, 8'h40, 8'h06, 6, -1, 88, 88, 1);
    for (int i = 0; i < 500 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("pending expected events", 32'(expQ.size()), 32'd0);
    checkOutput("final busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
